// File: rtl/seq_signed_divider.sv
// Sequential signed restoring divider: one quotient bit per clock on operand
// magnitudes, then sign correction and special-case forcing in a final FIX cycle.
module seq_signed_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         START,
  input  logic [N-1:0] DVD,
  input  logic [N-1:0] DVS,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         DONE,
  output logic         BUSY,
  output logic         DZ,
  output logic         OVF
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  // ---------------- control FSM ----------------
  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;
  logic          done_reg;

  logic load;
  logic step;
  logic fix;

  assign load = (state_reg == S_IDLE) && START;
  assign step = (state_reg == S_ITER);
  assign fix  = (state_reg == S_FIX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (START) begin
            state_reg <= S_ITER;
            cnt_reg   <= CW'(N);
            busy_reg  <= 1'b1;
          end
        end
        S_ITER: begin
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- datapath ----------------
  logic [N-1:0] a_reg;
  logic [N-1:0] m_reg;
  logic [N-1:0] p_reg;
  logic [N-1:0] dvd_reg;
  logic         dvd_neg_reg;
  logic         q_neg_reg;
  logic         dz_case_reg;
  logic         ovf_case_reg;
  logic [N-1:0] q_reg;
  logic [N-1:0] r_reg;
  logic         dz_reg;
  logic         ovf_reg;

  // Unsigned N-bit magnitude is exact even for the most negative value.
  logic [N-1:0] dvd_mag;
  logic [N-1:0] dvs_mag;
  logic [N:0]   p_sh;
  logic [N:0]   diff;
  logic         ge;

  always_comb begin
    dvd_mag = DVD[N-1] ? -DVD : DVD;
    dvs_mag = DVS[N-1] ? -DVS : DVS;
    // Partial remainder stays below M, so only the shifted value needs N+1 bits.
    p_sh    = {p_reg, a_reg[N-1]};
    diff    = p_sh - {1'b0, m_reg};
    ge      = ~diff[N];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      m_reg        <= '0;
      p_reg        <= '0;
      dvd_reg      <= '0;
      dvd_neg_reg  <= 1'b0;
      q_neg_reg    <= 1'b0;
      dz_case_reg  <= 1'b0;
      ovf_case_reg <= 1'b0;
      q_reg        <= '0;
      r_reg        <= '0;
      dz_reg       <= 1'b0;
      ovf_reg      <= 1'b0;
    end else if (load) begin
      a_reg        <= dvd_mag;
      m_reg        <= dvs_mag;
      p_reg        <= '0;
      dvd_reg      <= DVD;
      dvd_neg_reg  <= DVD[N-1];
      q_neg_reg    <= DVD[N-1] ^ DVS[N-1];
      dz_case_reg  <= (DVS == '0);
      ovf_case_reg <= (DVD == MIN_VAL) && (DVS == '1);
    end else if (step) begin
      p_reg <= ge ? diff[N-1:0] : p_sh[N-1:0];
      a_reg <= {a_reg[N-2:0], ge};
    end else if (fix) begin
      if (dz_case_reg) begin
        q_reg   <= '1;
        r_reg   <= dvd_reg;
        dz_reg  <= 1'b1;
        ovf_reg <= 1'b0;
      end else if (ovf_case_reg) begin
        q_reg   <= MIN_VAL;
        r_reg   <= '0;
        dz_reg  <= 1'b0;
        ovf_reg <= 1'b1;
      end else begin
        q_reg   <= q_neg_reg ? -a_reg : a_reg;
        r_reg   <= dvd_neg_reg ? -p_reg : p_reg;
        dz_reg  <= 1'b0;
        ovf_reg <= 1'b0;
      end
    end
  end

  assign Q    = q_reg;
  assign R    = r_reg;
  assign DONE = done_reg;
  assign BUSY = busy_reg;
  assign DZ   = dz_reg;
  assign OVF  = ovf_reg;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed quotient/remainder/latency.
module tb_seq_signed_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         START;
  logic [N-1:0] DVD;
  logic [N-1:0] DVS;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         DONE;
  logic         BUSY;
  logic         DZ;
  logic         OVF;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  seq_signed_divider #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .START(START),
    .DVD  (DVD),
    .DVS  (DVS),
    .Q    (Q),
    .R    (R),
    .DONE (DONE),
    .BUSY (BUSY),
    .DZ   (DZ),
    .OVF  (OVF)
  );

  // Reference arithmetic: truncating division, remainder follows the dividend.
  function automatic void ref_div(input int a, input int b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic dz, output logic ovf);
    int qi;
    int ri;
    int minv;
    minv = -(1 << (N - 1));
    dz   = 1'b0;
    ovf  = 1'b0;
    if (b == 0) begin
      qi = -1;
      ri = a;
      dz = 1'b1;
    end else if (a == minv && b == -1) begin
      qi  = minv;
      ri  = 0;
      ovf = 1'b1;
    end else begin
      qi = a / b;
      ri = a % b;
    end
    q = qi[N-1:0];
    r = ri[N-1:0];
  endfunction

  // Model: a request is taken when not busy; result appears N+1 edges later.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_done_at = -1;
  logic [N-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic         m_dz = 1'b0, m_ovf = 1'b0, p_dz = 1'b0, p_ovf = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
    m_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_done_at = -1;
      m_q = '0; m_r = '0; m_dz = 1'b0; m_ovf = 1'b0;
    end else if (m_busy && cyc == m_done_at) begin
      m_q = p_q; m_r = p_r; m_dz = p_dz; m_ovf = p_ovf;
      m_busy = 1'b0;
      m_done = 1'b1;
    end else if (!m_busy && START === 1'b1) begin
      ref_div(int'($signed(DVD)), int'($signed(DVS)), p_q, p_r, p_dz, p_ovf);
      m_done_at = cyc + N + 1;
      m_busy = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      checks++;
      if ({Q, R, DONE, BUSY, DZ, OVF} !== {m_q, m_r, m_done, m_busy, m_dz, m_ovf}) begin
        failures++;
        $display("FAIL cycle %0d: got Q=%h R=%h DONE=%b BUSY=%b DZ=%b OVF=%b, want Q=%h R=%h DONE=%b BUSY=%b DZ=%b OVF=%b",
                 cyc, Q, R, DONE, BUSY, DZ, OVF, m_q, m_r, m_done, m_busy, m_dz, m_ovf);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name, output int at);
    at = -1;
    for (int k = 0; k < 3 * N; k++) begin
      @(negedge clk);
      if (DONE === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL %s: DONE timeout got none want pulse", name);
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
    int t0;
    int at;
    DVD = a; DVS = b; START = 1'b1;
    tick();
    t0 = cyc;
    START = 1'b0;
    wait_done("run_op", at);
    lat = (at < 0) ? -1 : at - t0;
  endtask

  task automatic directed(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er,
                          input logic edz, input logic eovf);
    int lat;
    run_op(a, b, lat);
    check({name, " latency"}, lat, N + 1);
    check({name, " Q"}, Q, eq);
    check({name, " R"}, R, er);
    check({name, " DZ"}, DZ, edz);
    check({name, " OVF"}, OVF, eovf);
    $display("op %s: DVD=%h DVS=%h -> Q=%h R=%h DZ=%b OVF=%b lat=%0d", name, a, b, Q, R, DZ, OVF, lat);
  endtask

  initial begin
    int lat;
    int t0;
    int d1;
    int d2;
    logic [N-1:0] bvals [8];
    bvals = '{8'h80, 8'h81, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h7F};

    rst = 1'b1; START = 1'b0; DVD = '0; DVS = '0;
    tick(); tick();
    @(negedge clk);
    check("reset outputs", {Q, R, DONE, BUSY, DZ, OVF}, '0);
    rst = 1'b0;
    tick();

    directed("100/7",   8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0);
    directed("-100/7",  8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0);
    directed("100/-7",  8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);
    directed("-100/-7", 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0);
    directed("-128/3",  8'h80, 8'h03, 8'hD6, 8'hFE, 1'b0, 1'b0);
    directed("55/0",    8'h37, 8'h00, 8'hFF, 8'h37, 1'b1, 1'b0);
    directed("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
    directed("0/5",     8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0);

    // START and operand changes while busy must not disturb the running op.
    DVD = 8'h64; DVS = 8'h07; START = 1'b1;
    tick();
    t0 = cyc;
    START = 1'b0;
    repeat (3) tick();
    DVD = 8'h09; DVS = 8'h03; START = 1'b1;
    tick();
    START = 1'b0;
    wait_done("busy protect", d1);
    check("busy protect latency", d1 - t0, N + 1);
    check("busy protect Q", Q, 8'h0E);
    check("busy protect R", R, 8'h02);
    $display("op busy-protect: Q=%h R=%h lat=%0d", Q, R, d1 - t0);
    repeat (3) tick();

    // START held high: a new division is taken in the DONE cycle.
    DVD = 8'h64; DVS = 8'h07; START = 1'b1;
    tick();
    t0 = cyc;
    DVD = 8'h9C;
    wait_done("held start 1", d1);
    check("held start first Q", Q, 8'h0E);
    wait_done("held start 2", d2);
    START = 1'b0;
    check("held start first latency", d1 - t0, N + 1);
    check("held start second DONE", d2 - t0, 2 * N + 3);
    check("held start second Q", Q, 8'hF2);
    check("held start second R", R, 8'hFE);
    $display("op held-start: done1=%0d done2=%0d Q=%h R=%h", d1 - t0, d2 - t0, Q, R);
    tick();

    // Reset in the middle of iterating.
    DVD = 8'h64; DVS = 8'h07; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("mid reset outputs", {Q, R, DONE, BUSY, DZ, OVF}, '0);
    rst = 1'b0;
    repeat (12) tick();
    $display("op mid-reset: outputs Q=%h R=%h BUSY=%b", Q, R, BUSY);
    directed("127/127", 8'h7F, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0);

    // Boundary grid plus random pairs; results checked by the model each cycle.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        run_op(bvals[i], bvals[j], lat);
        check("grid latency", lat, N + 1);
        $display("op grid: DVD=%h DVS=%h -> Q=%h R=%h DZ=%b OVF=%b", bvals[i], bvals[j], Q, R, DZ, OVF);
      end
    end
    for (int i = 0; i < 1500; i++) begin
      run_op(N'($urandom), N'($urandom_range(0, 255)), lat);
      check("random latency", lat, N + 1);
      $display("op rand: DVD=%h DVS=%h -> Q=%h R=%h DZ=%b OVF=%b", DVD, DVS, Q, R, DZ, OVF);
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
